// File: rtl/fx3_slfifo_pkg.sv
// Shared constants for the FX3 slave-FIFO responder: socket addresses,
// sticky error bit positions and the word returned on a read underflow.
package fx3_slfifo_pkg;

    localparam logic [1:0] SOCK_RD = 2'b11;
    localparam logic [1:0] SOCK_WR = 2'b00;

    localparam int ERR_RD_UNDERFLOW = 0;
    localparam int ERR_WR_OVERFLOW  = 1;
    localparam int ERR_BAD_ADDR     = 2;

    localparam logic [31:0] UNDERFLOW_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/fx3_slave_fifo_responder_if.sv
// GPIF II synchronous slave-FIFO pin bundle. The master modport is the
// FPGA initiator; the slave modport is the FX3-side responder.
interface fx3_slave_fifo_responder_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] dq_in;
    logic [DATA_W-1:0] dq_out;
    logic              dq_oe;
    logic [1:0]        addr;
    logic              slcs_n;
    logic              slrd_n;
    logic              slwr_n;
    logic              sloe_n;
    logic              pktend_n;
    logic              flaga;
    logic              flagb;
    logic              flagc;
    logic              flagd;

    modport master (
        output dq_in, addr, slcs_n, slrd_n, slwr_n, sloe_n, pktend_n,
        input  dq_out, dq_oe, flaga, flagb, flagc, flagd
    );

    modport slave (
        input  dq_in, addr, slcs_n, slrd_n, slwr_n, sloe_n, pktend_n,
        output dq_out, dq_oe, flaga, flagb, flagc, flagd
    );
endinterface

// File: rtl/fx3_sfifo_buf.sv
// Synchronous FIFO with first-word-fall-through read, current and next-state
// counts, and a tag_prev strobe that sets the MSB of the newest stored word.
module fx3_sfifo_buf #(
    parameter  int W     = 32,
    parameter  int DEPTH = 512,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_pll,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             tag_prev,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, last_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, do_push, do_pop, tag_en;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        tag_en   = tag_prev & ~empty & ~do_push;
        last_ptr = wr_ptr_q - PTR_W'(1);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; pointer reset alone discards contents.
    always_ff @(posedge clk_pll) begin
        if (do_push)
            mem_q[wr_ptr_q] <= push_data;
        else if (tag_en)
            mem_q[last_ptr][W-1] <= 1'b1;
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// FX3-side responder for the GPIF II synchronous slave-FIFO bus: read socket
// fed by src_*, write socket drained by snk_*. Optional FX3_PKTEND_EN adds snk_last.
module fx3_slave_fifo_responder
    import fx3_slfifo_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 512,
    parameter  int RD_WM  = 6,
    parameter  int WR_WM  = 6,
    parameter  int RD_LAT = 2,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                            clk_pll,
    input  logic                            reset,
    fx3_slave_fifo_responder_if.slave       bus,
    input  logic [DATA_W-1:0]               src_data,
    input  logic                            src_valid,
    output logic                            src_ready,
    output logic [DATA_W-1:0]               snk_data,
    output logic                            snk_valid,
    input  logic                            snk_ready,
`ifdef FX3_PKTEND_EN
    output logic                            snk_last,
`endif
    output logic [2:0]                      err
);
    logic cs, rd_strobe, wr_strobe, bad_addr, wr_tag;
    logic rd_empty, wr_full;
    logic [DATA_W-1:0] rd_rd_data, rd_word;
    logic [CNT_W-1:0]  rd_count, rd_count_next, wr_count, wr_count_next, wr_free_next;

`ifdef FX3_PKTEND_EN
    localparam int WB_W = DATA_W + 1;
    logic [WB_W-1:0] wr_push_data, wr_rd_data;
    assign wr_push_data = {~bus.pktend_n, bus.dq_in};
    assign wr_tag       = cs & bus.slwr_n & ~bus.pktend_n & (bus.addr == SOCK_WR);
    assign snk_data     = wr_rd_data[DATA_W-1:0];
    assign snk_last     = wr_rd_data[DATA_W];
`else
    localparam int WB_W = DATA_W;
    logic [WB_W-1:0] wr_push_data, wr_rd_data;
    logic            unused_pktend;
    assign wr_push_data  = bus.dq_in;
    assign wr_tag        = 1'b0;
    assign snk_data      = wr_rd_data;
    assign unused_pktend = bus.pktend_n;
`endif

    logic                           src_ready_q, src_ready_d;
    logic [DATA_W-1:0]              dq_out_q, dq_out_d;
    logic                           dq_oe_q, dq_oe_d;
    logic [3:0]                     flags_q, flags_d;
    logic [2:0]                     err_q, err_d;
    logic [RD_LAT-1:0]              pipe_v_q, pipe_v_d;
    logic [RD_LAT-1:0][DATA_W-1:0]  pipe_data_q, pipe_data_d;

    assign cs        = ~bus.slcs_n;
    assign rd_strobe = cs & ~bus.slrd_n & (bus.addr == SOCK_RD);
    assign wr_strobe = cs & ~bus.slwr_n & (bus.addr == SOCK_WR);
    assign bad_addr  = cs & (~bus.slrd_n | ~bus.slwr_n) &
                       (bus.addr != SOCK_RD) & (bus.addr != SOCK_WR);
    assign rd_empty  = (rd_count == '0);
    assign wr_full   = (wr_count == CNT_W'(DEPTH));

    fx3_sfifo_buf #(.W(DATA_W), .DEPTH(DEPTH)) u_rd_buf (
        .clk_pll    (clk_pll),
        .reset      (reset),
        .push       (src_valid & src_ready_q),
        .push_data  (src_data),
        .pop        (rd_strobe),
        .tag_prev   (1'b0),
        .rd_data    (rd_rd_data),
        .count      (rd_count),
        .count_next (rd_count_next)
    );

    fx3_sfifo_buf #(.W(WB_W), .DEPTH(DEPTH)) u_wr_buf (
        .clk_pll    (clk_pll),
        .reset      (reset),
        .push       (wr_strobe),
        .push_data  (wr_push_data),
        .pop        (snk_valid & snk_ready),
        .tag_prev   (wr_tag),
        .rd_data    (wr_rd_data),
        .count      (wr_count),
        .count_next (wr_count_next)
    );

    always_comb begin
        rd_word      = rd_empty ? DATA_W'(UNDERFLOW_WORD) : rd_rd_data;
        // Every sampled read occupies a pipeline slot, underflow included.
        pipe_v_d     = {pipe_v_q[RD_LAT-2:0], rd_strobe};
        pipe_data_d  = {pipe_data_q[RD_LAT-2:0], rd_word};
        dq_out_d     = pipe_v_q[RD_LAT-1] ? pipe_data_q[RD_LAT-1] : dq_out_q;
        dq_oe_d      = cs & ~bus.sloe_n & (bus.addr == SOCK_RD);
        wr_free_next = CNT_W'(DEPTH) - wr_count_next;
        flags_d      = {rd_count_next > CNT_W'(RD_WM),
                        rd_count_next != '0,
                        wr_free_next > CNT_W'(WR_WM),
                        wr_free_next != '0};
        src_ready_d  = (rd_count_next != CNT_W'(DEPTH));
        err_d        = err_q;
        if (rd_strobe && rd_empty) err_d[ERR_RD_UNDERFLOW] = 1'b1;
        if (wr_strobe && wr_full)  err_d[ERR_WR_OVERFLOW]  = 1'b1;
        if (bad_addr)              err_d[ERR_BAD_ADDR]     = 1'b1;
    end

    always_ff @(posedge clk_pll) begin
        if (reset) begin
            src_ready_q <= 1'b0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            flags_q     <= '0;
            err_q       <= '0;
            pipe_v_q    <= '0;
            pipe_data_q <= '0;
        end else begin
            src_ready_q <= src_ready_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            pipe_v_q    <= pipe_v_d;
            pipe_data_q <= pipe_data_d;
        end
    end

    assign src_ready  = src_ready_q;
    assign snk_valid  = (wr_count != '0);
    assign err        = err_q;
    assign bus.dq_out = dq_out_q;
    assign bus.dq_oe  = dq_oe_q;
    assign bus.flaga  = flags_q[0];
    assign bus.flagb  = flags_q[1];
    assign bus.flagc  = flags_q[2];
    assign bus.flagd  = flags_q[3];

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// Directed bench for fx3_slave_fifo_responder with a 16-deep buffer and RD_LAT=2.
module tb_fx3_slave_fifo_responder;
    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;

    logic          clk_pll = 1'b0;
    logic          reset;
    logic [DW-1:0] src_data, snk_data;
    logic          src_valid, src_ready, snk_valid, snk_ready;
    logic [2:0]    err;
`ifdef FX3_PKTEND_EN
    logic          snk_last;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk_pll = ~clk_pll;

    fx3_slave_fifo_responder_if #(.DATA_W(DW)) bus ();

    fx3_slave_fifo_responder #(
        .DATA_W(DW), .DEPTH(DEPTH), .RD_WM(6), .WR_WM(6), .RD_LAT(RD_LAT)
    ) dut (
        .clk_pll   (clk_pll),
        .reset     (reset),
        .bus       (bus.slave),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .snk_data  (snk_data),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
`ifdef FX3_PKTEND_EN
        .snk_last  (snk_last),
`endif
        .err       (err)
    );

    task automatic tick();
        @(posedge clk_pll);
        #1;
    endtask

    task automatic idle();
        bus.slcs_n   = 1'b1;
        bus.slrd_n   = 1'b1;
        bus.slwr_n   = 1'b1;
        bus.sloe_n   = 1'b1;
        bus.pktend_n = 1'b1;
        bus.addr     = 2'b00;
        bus.dq_in    = '0;
    endtask

    task automatic test_reset();
        idle();
        src_valid = 1'b0; src_data = '0; snk_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        checks++; if (bus.dq_out !== 32'h0) begin errors++; $display("FAIL rst_dq_out: got %h want 0", bus.dq_out); end
        checks++; if (bus.dq_oe !== 1'b0) begin errors++; $display("FAIL rst_dq_oe: got %b want 0", bus.dq_oe); end
        checks++; if ({bus.flaga, bus.flagb, bus.flagc, bus.flagd} !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b%b%b%b want 0000", bus.flaga, bus.flagb, bus.flagc, bus.flagd); end
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL rst_src_ready: got %b want 0", src_ready); end
        checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL rst_snk_valid: got %b want 0", snk_valid); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b want 000", err); end
        reset = 1'b0;
        tick();
        checks++; if ({bus.flaga, bus.flagb, bus.flagc, bus.flagd} !== 4'b1100) begin errors++; $display("FAIL idle_flags: got %b%b%b%b want 1100", bus.flaga, bus.flagb, bus.flagc, bus.flagd); end
        checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL idle_src_ready: got %b want 1", src_ready); end
        checks++; if (bus.dq_oe !== 1'b0 || err !== 3'b000) begin errors++; $display("FAIL idle_oe_err: got oe=%b err=%b want 0/000", bus.dq_oe, err); end
    endtask

    task automatic test_read();
        logic [DW-1:0] exp_dq [7];
        logic          exp_fd [7];
        exp_dq = '{0, 0, 0, 0, 1, 2, 3};
        exp_fd = '{0, 1, 1, 1, 0, 0, 0};
        src_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            src_data = DW'(i);
            tick();
        end
        src_valid = 1'b0;
        checks++; if (bus.flagc !== 1'b1 || bus.flagd !== 1'b1) begin errors++; $display("FAIL load_flags: got c=%b d=%b want 1/1", bus.flagc, bus.flagd); end
        bus.slcs_n = 1'b0; bus.addr = 2'b11; bus.sloe_n = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            bus.slrd_n = (t <= 4) ? 1'b0 : 1'b1;
            tick();
            if (t == 1) begin
                checks++; if (bus.dq_oe !== 1'b1) begin errors++; $display("FAIL rd_dq_oe: got %b want 1", bus.dq_oe); end
            end
            if (t >= 3) begin
                checks++; if (bus.dq_out !== exp_dq[t]) begin errors++; $display("FAIL rd_data_t%0d: got %h want %h", t, bus.dq_out, exp_dq[t]); end
            end
            checks++; if (bus.flagd !== exp_fd[t]) begin errors++; $display("FAIL rd_flagd_t%0d: got %b want %b", t, bus.flagd, exp_fd[t]); end
        end
        checks++; if (bus.flagc !== 1'b1) begin errors++; $display("FAIL rd_flagc: got %b want 1", bus.flagc); end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] exp_dq [5];
        exp_dq = '{0, 32'd9, 32'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        bus.slrd_n = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        bus.slrd_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.flagc !== 1'b0 || err !== 3'b000) begin errors++; $display("FAIL drain_state: got flagc=%b err=%b want 0/000", bus.flagc, err); end
        checks++; if (bus.dq_out !== 32'd9) begin errors++; $display("FAIL drain_hold: got %h want 9", bus.dq_out); end
        for (int t = 1; t <= 4; t++) begin
            bus.slrd_n = (t <= 2) ? 1'b0 : 1'b1;
            tick();
            checks++; if (bus.dq_out !== exp_dq[t]) begin errors++; $display("FAIL uf_data_t%0d: got %h want %h", t, bus.dq_out, exp_dq[t]); end
        end
        checks++; if (err !== 3'b001 || bus.flagc !== 1'b0) begin errors++; $display("FAIL uf_err: got err=%b flagc=%b want 001/0", err, bus.flagc); end
        idle();
    endtask

    task automatic test_write();
        int c;
        snk_ready = 1'b0;
        bus.slcs_n = 1'b0; bus.addr = 2'b00; bus.slwr_n = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            bus.dq_in = 32'h100 + DW'(i);
            tick();
            c = (i + 1 > DEPTH) ? DEPTH : i + 1;
            checks++; if (bus.flagb !== (c < 10)) begin errors++; $display("FAIL wr_flagb_%0d: got %b want %b", i, bus.flagb, (c < 10)); end
            checks++; if (bus.flaga !== (c < DEPTH)) begin errors++; $display("FAIL wr_flaga_%0d: got %b want %b", i, bus.flaga, (c < DEPTH)); end
            checks++; if (err[1] !== (i == DEPTH)) begin errors++; $display("FAIL wr_ovf_%0d: got %b want %b", i, err[1], (i == DEPTH)); end
        end
        idle();
        tick();
        checks++; if (snk_valid !== 1'b1 || snk_data !== 32'h100) begin errors++; $display("FAIL snk_stall: got v=%b d=%h want 1/100", snk_valid, snk_data); end
        snk_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (snk_valid !== 1'b1 || snk_data !== 32'h100 + DW'(k)) begin errors++; $display("FAIL drain_%0d: got v=%b d=%h want 1/%h", k, snk_valid, snk_data, 32'h100 + DW'(k)); end
            tick();
        end
        checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL drain_end: got snk_valid=%b want 0", snk_valid); end
        checks++; if (bus.flaga !== 1'b1 || bus.flagb !== 1'b1) begin errors++; $display("FAIL drain_flags: got a=%b b=%b want 1/1", bus.flaga, bus.flagb); end
        snk_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        src_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            src_data = 32'h200 + DW'(i);
            tick();
        end
        checks++; if (bus.flagd !== 1'b1) begin errors++; $display("FAIL b2b_pre_flagd: got %b want 1", bus.flagd); end
        src_data = 32'h300;
        bus.slcs_n = 1'b0; bus.addr = 2'b11; bus.slrd_n = 1'b0; bus.sloe_n = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++; if (bus.flagd !== 1'b1 || src_ready !== 1'b1) begin errors++; $display("FAIL b2b_t%0d: got flagd=%b src_ready=%b want 1/1", t, bus.flagd, src_ready); end
        end
        checks++; if (bus.dq_out !== 32'h200) begin errors++; $display("FAIL b2b_data0: got %h want 200", bus.dq_out); end
        src_valid = 1'b0;
        tick();
        checks++; if (bus.flagd !== 1'b0) begin errors++; $display("FAIL b2b_count6: got flagd=%b want 0", bus.flagd); end
        checks++; if (bus.dq_out !== 32'h201) begin errors++; $display("FAIL b2b_data1: got %h want 201", bus.dq_out); end
        src_valid = 1'b1;
        reset = 1'b1;
        tick();
        checks++; if (bus.dq_out !== 32'h0 || bus.dq_oe !== 1'b0) begin errors++; $display("FAIL mid_rst_dq: got d=%h oe=%b want 0/0", bus.dq_out, bus.dq_oe); end
        checks++; if ({bus.flaga, bus.flagb, bus.flagc, bus.flagd} !== 4'b0000 || src_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b%b%b%b rdy=%b want 0000/0", bus.flaga, bus.flagb, bus.flagc, bus.flagd, src_ready); end
        checks++; if (err !== 3'b000 || snk_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got err=%b v=%b want 000/0", err, snk_valid); end
        reset = 1'b0; src_valid = 1'b0;
        idle();
        tick();
        checks++; if ({bus.flaga, bus.flagb, bus.flagc, bus.flagd} !== 4'b1100) begin errors++; $display("FAIL post_rst_flags: got %b%b%b%b want 1100", bus.flaga, bus.flagb, bus.flagc, bus.flagd); end
    endtask

    task automatic test_bad_addr();
        bus.slcs_n = 1'b0; bus.addr = 2'b00; bus.slrd_n = 1'b0;
        tick();
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rd_at_wr_sock: got err=%b want 000", err); end
        bus.slrd_n = 1'b1; bus.addr = 2'b11; bus.slwr_n = 1'b0;
        tick();
        checks++; if (err !== 3'b000 || snk_valid !== 1'b0) begin errors++; $display("FAIL wr_at_rd_sock: got err=%b v=%b want 000/0", err, snk_valid); end
        bus.addr = 2'b01;
        tick();
        idle();
        tick();
        checks++; if (err !== 3'b100 || snk_valid !== 1'b0) begin errors++; $display("FAIL bad_addr: got err=%b v=%b want 100/0", err, snk_valid); end
        checks++; if (bus.flaga !== 1'b1 || bus.flagc !== 1'b0) begin errors++; $display("FAIL bad_addr_flags: got a=%b c=%b want 1/0", bus.flaga, bus.flagc); end
    endtask

`ifdef FX3_PKTEND_EN
    task automatic test_pktend();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        bus.slcs_n = 1'b0; bus.addr = 2'b00; bus.slwr_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dq_in = 32'h400 + DW'(i);
            bus.pktend_n = (i == 2) ? 1'b0 : 1'b1;
            tick();
        end
        idle();
        snk_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (snk_last !== (k == 2) || snk_data !== 32'h400 + DW'(k)) begin errors++; $display("FAIL pktend_%0d: got last=%b d=%h want %b/%h", k, snk_last, snk_data, (k == 2), 32'h400 + DW'(k)); end
            tick();
        end
        snk_ready = 1'b0;
        bus.slcs_n = 1'b0; bus.slwr_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.dq_in = 32'h500 + DW'(i);
            tick();
        end
        bus.slwr_n = 1'b1; bus.pktend_n = 1'b0;
        tick();
        idle();
        snk_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (snk_last !== (k == 1)) begin errors++; $display("FAIL pktend_prev_%0d: got %b want %b", k, snk_last, (k == 1)); end
            tick();
        end
        snk_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_underflow();
        test_write();
        test_back_to_back();
        test_bad_addr();
`ifdef FX3_PKTEND_EN
        test_pktend();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
